// File: rtl/hr_bridge_if.sv
// rtl/hr_bridge_if.sv - ring-stop bus bundle for hr_bridge (six lanes: l0 l1 g0 g1 g2 g3)
interface hr_bridge_if;
  // Flits arriving on / leaving toward the ring, one per lane
  logic [143:0] port_l0_i, port_l1_i, port_g0_i, port_g1_i, port_g2_i, port_g3_i;
  logic [143:0] port_l0_o, port_l1_o, port_g0_o, port_g1_o, port_g2_o, port_g3_o;
  // Injection queue heads and ejected flits toward the transfer queues
  logic [143:0] FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i, FIFO_g2_i, FIFO_g3_i;
  logic [143:0] FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o, FIFO_g2_o, FIFO_g3_o;
  // Transfer queue full flags
  logic bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i, bfull_g2_i, bfull_g3_i;
  // Injection queue pops and transfer queue pushes
  logic deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o, deQ_g2_o, deQ_g3_o;
  logic enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o, enQ_g2_o, enQ_g3_o;

  // Ring / queue side: drives incoming flits, queue heads and full flags
  modport master (
    output port_l0_i, port_l1_i, port_g0_i, port_g1_i, port_g2_i, port_g3_i,
    output FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i, FIFO_g2_i, FIFO_g3_i,
    output bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i, bfull_g2_i, bfull_g3_i,
    input  port_l0_o, port_l1_o, port_g0_o, port_g1_o, port_g2_o, port_g3_o,
    input  FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o, FIFO_g2_o, FIFO_g3_o,
    input  deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o, deQ_g2_o, deQ_g3_o,
    input  enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o, enQ_g2_o, enQ_g3_o
  );

  // Bridge side
  modport slave (
    input  port_l0_i, port_l1_i, port_g0_i, port_g1_i, port_g2_i, port_g3_i,
    input  FIFO_l0_i, FIFO_l1_i, FIFO_g0_i, FIFO_g1_i, FIFO_g2_i, FIFO_g3_i,
    input  bfull_l0_i, bfull_l1_i, bfull_g0_i, bfull_g1_i, bfull_g2_i, bfull_g3_i,
    output port_l0_o, port_l1_o, port_g0_o, port_g1_o, port_g2_o, port_g3_o,
    output FIFO_l0_o, FIFO_l1_o, FIFO_g0_o, FIFO_g1_o, FIFO_g2_o, FIFO_g3_o,
    output deQ_l0_o, deQ_l1_o, deQ_g0_o, deQ_g1_o, deQ_g2_o, deQ_g3_o,
    output enQ_l0_o, enQ_l1_o, enQ_g0_o, enQ_g1_o, enQ_g2_o, enQ_g3_o
  );
endinterface

// File: rtl/hr_bridge.sv
// rtl/hr_bridge.sv - bufferless hierarchical-ring bridge, six lanes; optional HRB_DEFLECT_CNT_EN adds deflect_cnt_o
module hr_bridge #(
  parameter logic [3:0] RING_ID = 4'h5
) (
  input  logic        clk,
  input  logic        rst,
`ifdef HRB_DEFLECT_CNT_EN
  output logic [15:0] deflect_cnt_o,
`endif
  hr_bridge_if.slave  bus
);

  // Lanes 0,1 are the local-ring lanes (eject flits leaving this ring);
  // lanes 2..5 are global-ring lanes (eject flits arriving at this ring).
  localparam logic [5:0] LOCAL_MASK = 6'b000011;

  logic [5:0][143:0] p_in, f_in;
  logic [5:0]        bfull;

  logic [5:0]        hit, eject_n, deflect_n, occupied_n, inject_n;
  logic [5:0][143:0] port_n, fifo_n;

  logic [5:0][143:0] port_q, fifo_q;
  logic [5:0]        enq_q, deq_q;

  assign p_in[0] = bus.port_l0_i;
  assign p_in[1] = bus.port_l1_i;
  assign p_in[2] = bus.port_g0_i;
  assign p_in[3] = bus.port_g1_i;
  assign p_in[4] = bus.port_g2_i;
  assign p_in[5] = bus.port_g3_i;

  assign f_in[0] = bus.FIFO_l0_i;
  assign f_in[1] = bus.FIFO_l1_i;
  assign f_in[2] = bus.FIFO_g0_i;
  assign f_in[3] = bus.FIFO_g1_i;
  assign f_in[4] = bus.FIFO_g2_i;
  assign f_in[5] = bus.FIFO_g3_i;

  assign bfull = {bus.bfull_g3_i, bus.bfull_g2_i, bus.bfull_g1_i,
                  bus.bfull_g0_i, bus.bfull_l1_i, bus.bfull_l0_i};

  // Per-lane routing decision: eject, deflect, pass through or inject
  always_comb begin
    hit        = '0;
    eject_n    = '0;
    deflect_n  = '0;
    occupied_n = '0;
    inject_n   = '0;
    port_n     = '0;
    fifo_n     = '0;
    for (int i = 0; i < 6; i++) begin
      if (LOCAL_MASK[i])
        hit[i] = p_in[i][0] && (p_in[i][7:4] != RING_ID);
      else
        hit[i] = p_in[i][0] && (p_in[i][7:4] == RING_ID);
      eject_n[i]    = hit[i] && !bfull[i];
      deflect_n[i]  = hit[i] && bfull[i];
      // A flit that stays on the ring keeps the slot and blocks injection
      occupied_n[i] = p_in[i][0] && !eject_n[i];
      inject_n[i]   = !occupied_n[i] && f_in[i][0];
      if (occupied_n[i])
        port_n[i] = p_in[i];
      else if (inject_n[i])
        port_n[i] = f_in[i];
      if (eject_n[i])
        fifo_n[i] = p_in[i];
    end
  end

  // Register every lane output; reset clears and drops in-flight flits
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q <= '0;
      fifo_q <= '0;
      enq_q  <= '0;
      deq_q  <= '0;
    end else begin
      port_q <= port_n;
      fifo_q <= fifo_n;
      enq_q  <= eject_n;
      deq_q  <= inject_n;
    end
  end

  assign bus.port_l0_o = port_q[0];
  assign bus.port_l1_o = port_q[1];
  assign bus.port_g0_o = port_q[2];
  assign bus.port_g1_o = port_q[3];
  assign bus.port_g2_o = port_q[4];
  assign bus.port_g3_o = port_q[5];

  assign bus.FIFO_l0_o = fifo_q[0];
  assign bus.FIFO_l1_o = fifo_q[1];
  assign bus.FIFO_g0_o = fifo_q[2];
  assign bus.FIFO_g1_o = fifo_q[3];
  assign bus.FIFO_g2_o = fifo_q[4];
  assign bus.FIFO_g3_o = fifo_q[5];

  assign bus.enQ_l0_o = enq_q[0];
  assign bus.enQ_l1_o = enq_q[1];
  assign bus.enQ_g0_o = enq_q[2];
  assign bus.enQ_g1_o = enq_q[3];
  assign bus.enQ_g2_o = enq_q[4];
  assign bus.enQ_g3_o = enq_q[5];

  assign bus.deQ_l0_o = deq_q[0];
  assign bus.deQ_l1_o = deq_q[1];
  assign bus.deQ_g0_o = deq_q[2];
  assign bus.deQ_g1_o = deq_q[3];
  assign bus.deQ_g2_o = deq_q[4];
  assign bus.deQ_g3_o = deq_q[5];

`ifdef HRB_DEFLECT_CNT_EN
  logic [15:0] deflect_cnt_q;
  logic [2:0]  defl_sum;
  logic [16:0] cnt_sum;

  // Number of lanes deflecting this cycle and the unsaturated new count
  always_comb begin
    defl_sum = '0;
    for (int i = 0; i < 6; i++)
      defl_sum = defl_sum + {2'b00, deflect_n[i]};
    cnt_sum = {1'b0, deflect_cnt_q} + {14'd0, defl_sum};
  end

  // Saturating deflection counter
  always_ff @(posedge clk) begin
    if (rst)
      deflect_cnt_q <= '0;
    else if (cnt_sum[16])
      deflect_cnt_q <= 16'hFFFF;
    else
      deflect_cnt_q <= cnt_sum[15:0];
  end

  assign deflect_cnt_o = deflect_cnt_q;
`endif

endmodule

// File: tb/tb_hr_bridge.sv
// tb/tb_hr_bridge.sv - scoreboard testbench for hr_bridge
module tb_hr_bridge;
  localparam logic [3:0] RID = 4'h5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hr_bridge_if bif ();

`ifdef HRB_DEFLECT_CNT_EN
  logic [15:0] deflect_cnt;
  hr_bridge #(.RING_ID(RID)) dut (.clk(clk), .rst(rst), .deflect_cnt_o(deflect_cnt), .bus(bif));
`else
  hr_bridge #(.RING_ID(RID)) dut (.clk(clk), .rst(rst), .bus(bif));
`endif

  logic [5:0][143:0] in_port, in_fifo, out_port, out_fifo;
  logic [5:0]        in_bfull, out_enq, out_deq;

  assign bif.port_l0_i = in_port[0];
  assign bif.port_l1_i = in_port[1];
  assign bif.port_g0_i = in_port[2];
  assign bif.port_g1_i = in_port[3];
  assign bif.port_g2_i = in_port[4];
  assign bif.port_g3_i = in_port[5];
  assign bif.FIFO_l0_i = in_fifo[0];
  assign bif.FIFO_l1_i = in_fifo[1];
  assign bif.FIFO_g0_i = in_fifo[2];
  assign bif.FIFO_g1_i = in_fifo[3];
  assign bif.FIFO_g2_i = in_fifo[4];
  assign bif.FIFO_g3_i = in_fifo[5];
  assign bif.bfull_l0_i = in_bfull[0];
  assign bif.bfull_l1_i = in_bfull[1];
  assign bif.bfull_g0_i = in_bfull[2];
  assign bif.bfull_g1_i = in_bfull[3];
  assign bif.bfull_g2_i = in_bfull[4];
  assign bif.bfull_g3_i = in_bfull[5];

  assign out_port = {bif.port_g3_o, bif.port_g2_o, bif.port_g1_o, bif.port_g0_o, bif.port_l1_o, bif.port_l0_o};
  assign out_fifo = {bif.FIFO_g3_o, bif.FIFO_g2_o, bif.FIFO_g1_o, bif.FIFO_g0_o, bif.FIFO_l1_o, bif.FIFO_l0_o};
  assign out_enq  = {bif.enQ_g3_o, bif.enQ_g2_o, bif.enQ_g1_o, bif.enQ_g0_o, bif.enQ_l1_o, bif.enQ_l0_o};
  assign out_deq  = {bif.deQ_g3_o, bif.deQ_g2_o, bif.deQ_g1_o, bif.deQ_g0_o, bif.deQ_l1_o, bif.deQ_l0_o};

  typedef struct packed {
    logic [5:0][143:0] port;
    logic [5:0][143:0] fifo;
    logic [5:0]        enq;
    logic [5:0]        deq;
    logic [15:0]       cnt;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] cnt_model = '0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] flit(input logic [15:0] lo);
    return {$urandom(), $urandom(), $urandom(), $urandom(), lo};
  endfunction

  // Reference behaviour of one bridge cycle, derived lane by lane
  function automatic exp_t predict(input logic r);
    exp_t e;
    int   ndefl;
    logic wants, slot_free;
    logic [16:0] s;
    e = '0;
    ndefl = 0;
    if (r) begin
      e.cnt = 16'd0;
      return e;
    end
    for (int i = 0; i < 6; i++) begin
      slot_free = 1'b1;
      wants = (i < 2) ? (in_port[i][7:4] != RID) : (in_port[i][7:4] == RID);
      if (in_port[i][0]) begin
        if (wants && !in_bfull[i]) begin
          e.fifo[i] = in_port[i];
          e.enq[i]  = 1'b1;
        end else begin
          if (wants) ndefl++;
          e.port[i] = in_port[i];
          slot_free = 1'b0;
        end
      end
      if (slot_free && in_fifo[i][0]) begin
        e.port[i] = in_fifo[i];
        e.deq[i]  = 1'b1;
      end
    end
    s = {1'b0, cnt_model} + 17'(ndefl);
    e.cnt = (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
    return e;
  endfunction

  task automatic step(input string name);
    exp_t e;
    e = predict(rst);
    cnt_model = e.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s port%0d", name, i), out_port[i], e.port[i]);
      check($sformatf("%s fifo%0d", name, i), out_fifo[i], e.fifo[i]);
      check($sformatf("%s enq%0d", name, i), 144'(out_enq[i]), 144'(e.enq[i]));
      check($sformatf("%s deq%0d", name, i), 144'(out_deq[i]), 144'(e.deq[i]));
    end
`ifdef HRB_DEFLECT_CNT_EN
    check($sformatf("%s cnt", name), 144'(deflect_cnt), 144'(e.cnt));
`endif
  endtask

  task automatic clear_inputs();
    in_port  = '0;
    in_fifo  = '0;
    in_bfull = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] t;
    rst = 1'b1;
    clear_inputs();
    step("reset");
    step("reset2");
    rst = 1'b0;

    // Mixed ejection, with absolute expectations on top of the scoreboard
    in_port[0] = flit(16'h1851);
    in_port[1] = flit(16'h1850);
    in_port[2] = flit(16'h1854);
    in_port[3] = flit(16'h1857);
    in_port[4] = flit(16'h185a);
    in_port[5] = flit(16'h185f);
    t = in_port[3];
    step("mixed");
    check("mixed abs port_l0", out_port[0], in_port[0]);
    check("mixed abs fifo_g1", out_fifo[3], t);
    check("mixed abs enq", 144'(out_enq), 144'(6'b101000));

    clear_inputs();
    step("idle");

    in_port[3]  = flit(16'h1857);
    in_bfull[3] = 1'b1;
    step("deflect");
    check("deflect abs port_g1", out_port[3], in_port[3]);

    clear_inputs();
    in_port[0] = flit(16'h1861);
    in_fifo[0] = flit(16'h0051);
    step("ej_inj");
    check("ej_inj abs port_l0", out_port[0], in_fifo[0]);
    check("ej_inj abs fifo_l0", out_fifo[0], in_port[0]);

    clear_inputs();
    in_port[0] = flit(16'h1851);
    in_fifo[0] = flit(16'h0051);
    step("blocked");
    check("blocked abs deq", 144'(out_deq[0]), 144'(1'b0));

    // All lanes deflecting at once, then repeated to exercise the counter
    for (int i = 0; i < 6; i++) begin
      in_port[i]  = flit({8'h18, (i < 2) ? 4'h7 : RID, 4'h1});
      in_bfull[i] = 1'b1;
      in_fifo[i]  = flit(16'h0021);
    end
    step("defl_all");
    step("defl_all2");

    // Reset with traffic in flight
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    clear_inputs();
    step("post_rst");

    // Random traffic, including back-to-back transfers
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 6; i++) begin
        logic [3:0] d;
        d = ($urandom_range(0, 1) == 0) ? RID : 4'($urandom_range(0, 15));
        in_port[i]  = flit({8'($urandom()), d, 3'($urandom()), 1'($urandom_range(0, 3) != 0)});
        in_fifo[i]  = flit({15'($urandom()), 1'($urandom_range(0, 1))});
        in_bfull[i] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 60) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hr_bridge.md
HR_BRIDGE -- requirements
Module: hr_bridge

Interface
REQ-001 Parameter RING_ID, default 4'h5: ring identifier of the local ring served by this bridge.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 port_{l0,l1,g0,g1,g2,g3}_i  input  144 each  flit arriving on ring slot X (l* = local-ring lanes, g* = global-ring lanes).
REQ-005 port_{l0,l1,g0,g1,g2,g3}_o  output  144 each  flit leaving on ring slot X toward the next ring stop.
REQ-006 FIFO_{l0,...,g3}_i  input  144 each  head entry of injection queue X (valid bit 0 = queue empty).
REQ-007 FIFO_{l0,...,g3}_o  output  144 each  flit ejected from slot X into transfer queue X.
REQ-008 bfull_{l0,...,g3}_i  input  1 each  transfer queue X is full.
REQ-009 deQ_{l0,...,g3}_o  output  1 each  pop injection queue X.
REQ-010 enQ_{l0,...,g3}_o  output  1 each  push FIFO_X_o into transfer queue X.

Function
REQ-011 Flit fields: bit 0 = valid; bits [7:4] = destination ring; all other bits are payload carried unchanged.
REQ-012 All six lanes are independent, identical, bufferless stages; every output is registered, giving 1-cycle latency.
REQ-013 Eject condition, local lane: port valid AND dst != RING_ID.
REQ-014 Eject condition, global lane: port valid AND dst == RING_ID.
REQ-015 If the eject condition holds and bfull_X_i=0: next cycle FIFO_X_o = flit, enQ_X_o = 1, and the slot is freed.
REQ-016 If the eject condition holds and bfull_X_i=1: the flit is deflected, i.e. next cycle port_X_o = flit and enQ_X_o = 0.
REQ-017 A valid flit with no eject condition passes through: next cycle port_X_o = flit.
REQ-018 Free slot (incoming invalid, or ejected this cycle) with FIFO_X_i valid: next cycle port_X_o = FIFO_X_i and deQ_X_o = 1; eject and inject may occur in the same cycle.
REQ-019 An occupied slot (pass-through or deflection) blocks injection: deQ_X_o = 0 and FIFO_X_i waits.
REQ-020 A free slot with no injection drives port_X_o = 0 next cycle.
REQ-021 When enQ_X_o = 0, FIFO_X_o = 0.
REQ-022 deQ/enQ are single-cycle pulses per transfer; back-to-back transfers may assert them on consecutive cycles.

Reset
REQ-023 While rst = 1 at a clock edge, all port_*_o and FIFO_*_o are cleared to 0, all deQ_*_o and enQ_*_o are cleared to 0, and any counters are cleared to 0.
REQ-024 Flits presented during a reset cycle are dropped; rst has priority over every transfer.

Configuration
REQ-025 With HRB_DEFLECT_CNT_EN defined, the bridge adds output deflect_cnt_o (16 bits), which increments once per lane deflection per cycle (0 to 6 per cycle), saturates at 16'hFFFF, and resets to 0.
REQ-026 Without HRB_DEFLECT_CNT_EN, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-027 Scenario, mixed ejection: RING_ID = 5; l0 = ...1851, l1 = ...1850, g0 = ...1854, g1 = ...1857, g2 = ...185a, g3 = ...185f; bfull all 0 -> after 1 edge: port_l0_o = ...1851; FIFO_g1_o and FIFO_g3_o carry their flits with enQ_g1 = enQ_g3 = 1; all other outputs 0.
REQ-028 Scenario, idle: all inputs zeroed on the next edge -> all outputs 0.
REQ-029 Scenario, deflection: g1 = ...1857 with bfull_g1 = 1 -> port_g1_o = ...1857, enQ_g1 = 0.
REQ-030 Scenario, eject plus inject: l0 = ...1861 (dst 6), FIFO_l0_i = ...0051 valid, bfull_l0 = 0 -> enQ_l0 = 1, FIFO_l0_o = ...1861, deQ_l0 = 1, port_l0_o = ...0051.
REQ-031 Scenario, blocked injection: l0 = ...1851 pass-through with FIFO_l0_i valid -> deQ_l0 = 0, port_l0_o = ...1851.
REQ-032 Scenario, reset mid-traffic: assert rst while flits are in flight -> all outputs 0 on the next edge.
